// File: rtl/ps2_pkg.sv
// Shared PS/2 scancode constants and sequencer state encoding.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_BREAK   = 2'd1,
        ST_ISSUE   = 2'd2
    } state_t;

    // True for codes that steer the line editor rather than being stored.
    function automatic logic is_control(input logic [7:0] code);
        return (code == SC_BREAK) || (code == SC_EXT) || (code == SC_ENTER) ||
               (code == SC_BKSP)  || (code == SC_ESC);
    endfunction

endpackage

// File: rtl/ps2_cmd_sequencer_if.sv
// Command frame valid/ready channel between sequencer and interpreter.
interface ps2_cmd_sequencer_if #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [8*MAX_LEN-1:0]   cmd_data;
    logic [LEN_W-1:0]       cmd_len;

    modport master (output cmd_valid, output cmd_data, output cmd_len, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_data, input  cmd_len, output cmd_ready);
endinterface

// File: rtl/ps2_edge_accept.sv
// Turns the receiver's data-valid level into a single-cycle accept on its rising edge.
module ps2_edge_accept (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_flag,
    output logic o_accept_c
);
    logic r_flag_d;

    // Delayed copy of flag for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_flag_d <= 1'b0;
        else       r_flag_d <= i_flag;
    end

    assign o_accept_c = i_flag & ~r_flag_d;
endmodule

// File: rtl/ps2_cmd_sequencer.sv
// Line editor between PS/2 receiver and command interpreter: collects make-codes,
// filters break/extended traffic, and hands complete lines out as frames.
module ps2_cmd_sequencer
    import ps2_pkg::*;
#(
    parameter int unsigned MAX_LEN     = 8,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned LEN_W       = 4
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                flag,
    input  logic [7:0]          Dato,
    ps2_cmd_sequencer_if.master cmd,
    output logic                busy,
    output logic                err,
    output logic [7:0]          lost_cnt
);
    localparam int unsigned TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic                       w_accept;
    state_t                     r_state;
    state_t                     w_state_nxt;

    logic [MAX_LEN-1:0][7:0]    r_buf;
    logic [LEN_W-1:0]           r_len;
    logic                       r_ovf;
    logic [TMR_W-1:0]           r_timer;

    logic                       r_cmd_valid;
    logic [8*MAX_LEN-1:0]       r_cmd_data;
    logic [LEN_W-1:0]           r_cmd_len;
    logic                       r_busy;
    logic                       r_err;
    logic [7:0]                 r_lost_cnt;

    logic                       w_active;
    logic                       w_timeout;
    logic                       w_consume;
    logic                       w_store;
    logic                       w_set_ovf;
    logic                       w_bksp;
    logic                       w_clear;
    logic                       w_err_set;
    logic                       w_issue;
    logic                       w_lost;

    ps2_edge_accept u_edge (
        .i_clk      (CLK),
        .i_rst      (reset),
        .i_flag     (flag),
        .o_accept_c (w_accept)
    );

    assign w_active  = (r_len != '0) || r_ovf;
    assign w_timeout = (r_state != ST_ISSUE) && w_active && !w_accept &&
                       (r_timer == TMR_W'(TIMEOUT_CYC - 1));
    assign w_consume = (r_state == ST_ISSUE) && r_cmd_valid && cmd.cmd_ready;

    // State register.
    always_ff @(posedge CLK) begin
        if (reset) r_state <= ST_COLLECT;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_COLLECT: begin
                if (w_accept) begin
                    if (Dato == SC_BREAK)
                        w_state_nxt = ST_BREAK;
                    else if ((Dato == SC_ENTER) && !r_ovf && (r_len != '0))
                        w_state_nxt = ST_ISSUE;
                end
            end
            ST_BREAK: begin
                if (w_accept || w_timeout) w_state_nxt = ST_COLLECT;
            end
            ST_ISSUE: begin
                if (w_consume) w_state_nxt = ST_COLLECT;
            end
            default: w_state_nxt = ST_COLLECT;
        endcase
    end

    // Action decode driving the line buffer and output registers.
    always_comb begin
        w_store   = 1'b0;
        w_set_ovf = 1'b0;
        w_bksp    = 1'b0;
        w_clear   = w_timeout || w_consume;
        w_err_set = w_timeout;
        w_issue   = 1'b0;
        w_lost    = 1'b0;
        if ((r_state == ST_COLLECT) && w_accept) begin
            if (!is_control(Dato)) begin
                if (r_len < LEN_W'(MAX_LEN)) w_store   = 1'b1;
                else                         w_set_ovf = 1'b1;
            end
            if ((Dato == SC_BKSP) && (r_len != '0)) w_bksp = 1'b1;
            if (Dato == SC_ESC) w_clear = 1'b1;
            if ((Dato == SC_ENTER) && r_ovf) begin
                w_clear   = 1'b1;
                w_err_set = 1'b1;
            end
            if ((Dato == SC_ENTER) && !r_ovf && (r_len != '0)) w_issue = 1'b1;
        end
        if ((r_state == ST_ISSUE) && w_accept) w_lost = 1'b1;
    end

    // Line buffer, idle timer and frame registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_buf       <= '0;
            r_len       <= '0;
            r_ovf       <= 1'b0;
            r_timer     <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_data  <= '0;
            r_cmd_len   <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_lost_cnt  <= 8'd0;
        end else begin
            r_err <= w_err_set;

            if (w_clear) begin
                r_buf <= '0;
                r_len <= '0;
                r_ovf <= 1'b0;
            end else begin
                if (w_store) begin
                    for (int unsigned i = 0; i < MAX_LEN; i++)
                        if (LEN_W'(i) == r_len) r_buf[i] <= Dato;
                    r_len <= r_len + LEN_W'(1);
                end
                if (w_set_ovf) r_ovf <= 1'b1;
                if (w_bksp) begin
                    for (int unsigned i = 0; i < MAX_LEN; i++)
                        if (LEN_W'(i) == (r_len - LEN_W'(1))) r_buf[i] <= 8'd0;
                    r_len <= r_len - LEN_W'(1);
                end
            end

            // Idle timer runs only while a partial line is waiting in COLLECT/BREAK.
            if ((r_state == ST_ISSUE) || !w_active || w_accept || w_timeout)
                r_timer <= '0;
            else
                r_timer <= r_timer + TMR_W'(1);

            if (w_issue) begin
                r_cmd_valid <= 1'b1;
                r_busy      <= 1'b1;
                r_cmd_data  <= r_buf;
                r_cmd_len   <= r_len;
            end else if (w_consume) begin
                r_cmd_valid <= 1'b0;
                r_busy      <= 1'b0;
            end

            if (w_lost && (r_lost_cnt != 8'hFF)) r_lost_cnt <= r_lost_cnt + 8'd1;
        end
    end

    assign cmd.cmd_valid = r_cmd_valid;
    assign cmd.cmd_data  = r_cmd_data;
    assign cmd.cmd_len   = r_cmd_len;
    assign busy          = r_busy;
    assign err           = r_err;
    assign lost_cnt      = r_lost_cnt;
endmodule
